// File: rtl/result_collector.sv
// Deskews the staggered column outputs of a systolic array into whole rows, buffers one
// frame of MATRIX_SIZE rows, then drains it row by row over a valid/ready handshake.
module result_collector #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_sum [MATRIX_SIZE],
  input  logic                 in_valid,
  output logic [DATA_SIZE-1:0] out_row [MATRIX_SIZE],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned PtrW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MATRIX_SIZE - 1);

  typedef enum logic [0:0] {StCollect, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_SIZE-1:0]   frame_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0]   frame_d [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0]   row_data [MATRIX_SIZE];
  logic                   row_valid, vld_busy, wr_en, xfer, last_xfer;

  // Column j arrives j cycles after column 0, so it waits MATRIX_SIZE-1-j stages.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int unsigned Depth = MATRIX_SIZE - 1 - j;
    if (Depth == 0) begin : g_pass
      assign row_data[j] = in_sum[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] sr_q [Depth];
      logic [DATA_SIZE-1:0] sr_d [Depth];
      always_comb begin
        sr_d[0] = in_sum[j];
        for (int k = 1; k < int'(Depth); k++) sr_d[k] = sr_q[k-1];
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < int'(Depth); k++) sr_q[k] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end
      assign row_data[j] = sr_q[Depth-1];
    end
  end

  if (MATRIX_SIZE > 1) begin : g_vld
    logic [MATRIX_SIZE-2:0] vld_q, vld_d;
    always_comb begin
      vld_d[0] = in_valid;
      for (int k = 1; k < int'(MATRIX_SIZE) - 1; k++) vld_d[k] = vld_q[k-1];
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_q <= '0;
      else        vld_q <= vld_d;
    end
    assign row_valid = vld_q[MATRIX_SIZE-2];
    assign vld_busy  = |vld_q;
  end else begin : g_novld
    assign row_valid = in_valid;
    assign vld_busy  = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StCollect;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never read before a full frame has been written, so it needs no reset.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    frame_d    = frame_q;
    xfer       = (state_q == StDrain) && out_ready;
    last_xfer  = xfer && (rd_ptr_q == LastPtr);
    // A row landing on the final transfer starts the next frame instead of overflowing.
    wr_en      = row_valid && ((state_q == StCollect) || last_xfer);

    if (xfer) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (last_xfer) begin
      rd_ptr_d = '0;
      state_d  = StCollect;
    end
    if (row_valid && (state_q == StDrain) && !last_xfer) overflow_d = 1'b1;

    if (wr_en) begin
      for (int j = 0; j < int'(MATRIX_SIZE); j++) frame_d[wr_ptr_q][j] = row_data[j];
      if (wr_ptr_q == LastPtr) begin
        wr_ptr_d = '0;
        state_d  = StDrain;
      end else begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == StDrain);
    out_last  = out_valid && (rd_ptr_q == LastPtr);
    busy      = out_valid || vld_busy;
    overflow  = overflow_q;
    for (int j = 0; j < int'(MATRIX_SIZE); j++) begin
      out_row[j] = out_valid ? frame_q[rd_ptr_q][j] : '0;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (2x2, 32-bit): reset, deskew, backpressure,
// overflow, concurrent write/drain and mid-drain reset.
module tb_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_sum [2];
  logic        in_valid;
  logic [31:0] out_row [2];
  logic        out_valid, out_ready, out_last, busy, overflow;

  int checks = 0;
  int errors = 0;

  result_collector #(
    .MATRIX_SIZE(2),
    .DATA_SIZE  (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_sum   (in_sum),
    .in_valid (in_valid),
    .out_row  (out_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] row();
    return {out_row[0], out_row[1]};
  endfunction

  // Drives one staggered 2-row frame {a0,a1},{b0,b1}; returns at the first DRAIN cycle.
  task automatic send_frame(input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] b0, input logic [31:0] b1);
    in_valid  = 1'b1; in_sum[0] = a0; in_sum[1] = '0;
    tick();
    check("busy_inflight", {63'd0, busy}, 64'd1);
    in_valid  = 1'b1; in_sum[0] = b0; in_sum[1] = a1;
    tick();
    in_valid  = 1'b0; in_sum[0] = '0; in_sum[1] = b1;
    tick();
    in_sum[1] = '0;
  endtask

  initial begin
    // Reset held with garbage on the inputs
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_sum[0] = 32'hdead_beef; in_sum[1] = 32'hcafe_f00d;
    repeat (3) tick();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_row", row(), 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b1; in_valid = 1'b0; in_sum[0] = '0; in_sum[1] = '0;
    tick();
    tick();
    check("idle_valid", {63'd0, out_valid}, 64'd0);

    // Deskew with consumer always ready
    send_frame(32'd1, 32'd2, 32'd3, 32'd4);
    check("dsk_valid", {63'd0, out_valid}, 64'd1);
    check("dsk_row0", row(), {32'd1, 32'd2});
    check("dsk_last0", {63'd0, out_last}, 64'd0);
    check("dsk_busy", {63'd0, busy}, 64'd1);
    tick();
    check("dsk_row1", row(), {32'd3, 32'd4});
    check("dsk_last1", {63'd0, out_last}, 64'd1);
    tick();
    check("dsk_done_valid", {63'd0, out_valid}, 64'd0);
    check("dsk_done_row", row(), 64'd0);
    check("dsk_done_last", {63'd0, out_last}, 64'd0);
    check("dsk_done_busy", {63'd0, busy}, 64'd0);

    // Backpressure: row 0 held for five cycles
    out_ready = 1'b0;
    send_frame(32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_row", row(), {32'd1, 32'd2});
      check("bp_last", {63'd0, out_last}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    check("bp_rel_row0", row(), {32'd1, 32'd2});
    tick();
    check("bp_rel_row1", row(), {32'd3, 32'd4});
    check("bp_rel_last", {63'd0, out_last}, 64'd1);
    tick();
    check("bp_end_valid", {63'd0, out_valid}, 64'd0);
    check("bp_ovf", {63'd0, overflow}, 64'd0);

    // Overflow: a row completing while the frame is stalled is dropped
    out_ready = 1'b0;
    send_frame(32'd1, 32'd2, 32'd3, 32'd4);
    in_valid = 1'b1; in_sum[0] = 32'd9;
    tick();
    in_valid = 1'b0; in_sum[0] = '0; in_sum[1] = 32'd9;
    check("ovf_not_yet", {63'd0, overflow}, 64'd0);
    tick();
    in_sum[1] = '0;
    check("ovf_set", {63'd0, overflow}, 64'd1);
    check("ovf_row0", row(), {32'd1, 32'd2});
    out_ready = 1'b1;
    tick();
    check("ovf_row1", row(), {32'd3, 32'd4});
    tick();
    check("ovf_end_valid", {63'd0, out_valid}, 64'd0);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Concurrent: row {5,6} completes on the final transfer of {3,4}
    reset = 1'b0;
    tick();
    check("rst2_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    send_frame(32'd1, 32'd2, 32'd3, 32'd4);
    check("cc_row0", row(), {32'd1, 32'd2});
    in_valid = 1'b1; in_sum[0] = 32'd5;
    tick();
    in_valid = 1'b0; in_sum[0] = '0; in_sum[1] = 32'd6;
    check("cc_row1", row(), {32'd3, 32'd4});
    tick();
    check("cc_valid_after", {63'd0, out_valid}, 64'd0);
    check("cc_ovf", {63'd0, overflow}, 64'd0);
    in_valid = 1'b1; in_sum[0] = 32'd7; in_sum[1] = '0;
    tick();
    in_valid = 1'b0; in_sum[0] = '0; in_sum[1] = 32'd8;
    check("cc_wait_valid", {63'd0, out_valid}, 64'd0);
    tick();
    in_sum[1] = '0;
    check("cc_next_row0", row(), {32'd5, 32'd6});
    check("cc_next_last0", {63'd0, out_last}, 64'd0);
    tick();
    check("cc_next_row1", row(), {32'd7, 32'd8});
    check("cc_next_last1", {63'd0, out_last}, 64'd1);
    tick();
    check("cc_ovf_end", {63'd0, overflow}, 64'd0);

    // Mid-drain reset after the first transfer
    send_frame(32'd1, 32'd2, 32'd3, 32'd4);
    check("mdr_row0", row(), {32'd1, 32'd2});
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("mdr_valid", {63'd0, out_valid}, 64'd0);
    check("mdr_row", row(), 64'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mdr_after_valid", {63'd0, out_valid}, 64'd0);
      check("mdr_after_row", row(), 64'd0);
      check("mdr_after_busy", {63'd0, busy}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
